// File: rtl/captura_clave.sv
// Keypad PIN capture: two BCD digits + ENTER -> 8-bit PIN with a one-cycle ready strobe.
// Active only while a vehicle is present; CLEAR, inactivity timeout or departure discard partial input.
module captura_clave #(
   parameter int          TIMEOUT_CICLOS = 1000,
   parameter logic [3:0]  COD_ENTER      = 4'hE,
   parameter logic [3:0]  COD_BORRAR     = 4'hC
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       sensor_llegada_vehiculo,
   input  logic       tecla_valida,
   input  logic [3:0] tecla_codigo,
   output logic [7:0] clave_ingresada,
   output logic       clave_lista,
   output logic       error_entrada,
   output logic       tiempo_agotado,
   output logic [1:0] digitos
);

   localparam int CW = $clog2(TIMEOUT_CICLOS);
   localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CICLOS - 1);

   typedef enum logic [2:0] {
      INACTIVO,
      ESPERA_D1,
      ESPERA_D2,
      ESPERA_ENTER,
      ENTREGA
   } estado_t;

   estado_t       estado_q, estado_d;
   logic [7:0]    buf_q, buf_d;
   logic [1:0]    digitos_q, digitos_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [7:0]    clave_q, clave_d;
   logic          lista_q, lista_d;
   logic          error_q, error_d;
   logic          tiempo_q, tiempo_d;

   logic          es_digito, es_enter, es_borrar, tecla_ok;
   logic [CW-1:0] cnt_inc;
   logic          expira;

   always_comb begin
      es_digito = (tecla_codigo <= 4'd9);
      es_enter  = (tecla_codigo == COD_ENTER);
      es_borrar = (tecla_codigo == COD_BORRAR);
      tecla_ok  = tecla_valida && (es_digito || es_enter || es_borrar);
      cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
      expira    = (cnt_inc == CNT_MAX);
   end

   always_comb begin
      estado_d  = estado_q;
      buf_d     = buf_q;
      digitos_d = digitos_q;
      cnt_d     = '0;
      clave_d   = clave_q;
      lista_d   = 1'b0;
      error_d   = 1'b0;
      tiempo_d  = 1'b0;

      if (!sensor_llegada_vehiculo) begin
         estado_d  = INACTIVO;
         buf_d     = '0;
         digitos_d = '0;
      end else begin
         case (estado_q)
            INACTIVO, ENTREGA: begin
               estado_d  = ESPERA_D1;
               buf_d     = '0;
               digitos_d = '0;
            end
            ESPERA_D1: begin
               if (tecla_ok) begin
                  if (es_digito) begin
                     buf_d     = {tecla_codigo, 4'h0};
                     digitos_d = 2'd1;
                     estado_d  = ESPERA_D2;
                  end else if (es_enter) begin
                     error_d = 1'b1;
                  end
               end
            end
            ESPERA_D2: begin
               if (tecla_ok) begin
                  if (es_digito) begin
                     buf_d[3:0] = tecla_codigo;
                     digitos_d  = 2'd2;
                     estado_d   = ESPERA_ENTER;
                  end else begin
                     error_d   = es_enter;
                     buf_d     = '0;
                     digitos_d = '0;
                     estado_d  = ESPERA_D1;
                  end
               end else if (expira) begin
                  tiempo_d  = 1'b1;
                  buf_d     = '0;
                  digitos_d = '0;
                  estado_d  = ESPERA_D1;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
            ESPERA_ENTER: begin
               // A key in the expiry cycle takes precedence over the timeout.
               if (tecla_ok) begin
                  buf_d     = '0;
                  digitos_d = '0;
                  if (es_enter) begin
                     clave_d  = buf_q;
                     lista_d  = 1'b1;
                     estado_d = ENTREGA;
                  end else begin
                     error_d  = es_digito;
                     estado_d = ESPERA_D1;
                  end
               end else if (expira) begin
                  tiempo_d  = 1'b1;
                  buf_d     = '0;
                  digitos_d = '0;
                  estado_d  = ESPERA_D1;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
            default: begin
               estado_d  = INACTIVO;
               buf_d     = '0;
               digitos_d = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         estado_q  <= INACTIVO;
         buf_q     <= '0;
         digitos_q <= '0;
         cnt_q     <= '0;
         clave_q   <= '0;
         lista_q   <= 1'b0;
         error_q   <= 1'b0;
         tiempo_q  <= 1'b0;
      end else begin
         estado_q  <= estado_d;
         buf_q     <= buf_d;
         digitos_q <= digitos_d;
         cnt_q     <= cnt_d;
         clave_q   <= clave_d;
         lista_q   <= lista_d;
         error_q   <= error_d;
         tiempo_q  <= tiempo_d;
      end
   end

   assign clave_ingresada = clave_q;
   assign clave_lista     = lista_q;
   assign error_entrada   = error_q;
   assign tiempo_agotado  = tiempo_q;
   assign digitos         = digitos_q;

endmodule

// File: doc/captura_clave.md
Name: captura_clave

Overview:
- Upstream stage of the parking access controller.
- Collects two BCD digits from the keypad scanner, waits for ENTER, then presents the 8-bit PIN on clave_ingresada with a one-cycle clave_lista strobe.
- Active only while a vehicle is at the gate (sensor_llegada_vehiculo high).
- Discards partial entries on CLEAR, on inactivity timeout, or when the vehicle leaves.

Parameters:
TIMEOUT_CICLOS, 1000, cycles without an accepted key before a partial entry is discarded (≥2)
COD_ENTER, 4'hE, key code for ENTER
COD_BORRAR, 4'hC, key code for CLEAR

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
sensor_llegada_vehiculo  input  1  vehicle-present level; enables capture
tecla_valida  input  1  one-cycle strobe; tecla_codigo valid this cycle
tecla_codigo  input  4  key code; 0-9 digits, COD_ENTER, COD_BORRAR; others ignored
clave_ingresada  output  8  {first digit, second digit}, BCD; registered, held between deliveries
clave_lista  output  1  one-cycle pulse; clave_ingresada newly valid
error_entrada  output  1  one-cycle pulse on malformed sequence
tiempo_agotado  output  1  one-cycle pulse when timeout discards a partial entry
digitos  output  2  digits currently buffered (0..2), for display

Behaviour:
- Reset and clock: reset is synchronous, active-high; clock is clock.
  - On reset: state INACTIVO, clave_ingresada=8'h00, clave_lista=0, error_entrada=0, tiempo_agotado=0, digitos=0, digit buffer and timeout counter=0.
- Registers: all outputs are registered. A key sampled in cycle N produces its response in cycle N+1.
- States:
  - INACTIVO
  - ESPERA_D1
  - ESPERA_D2
  - ESPERA_ENTER
  - ENTREGA
- Priority each cycle: reset > sensor_llegada_vehiculo low > accepted key > timeout.
- Vehicle leaves: sensor low in any state -> INACTIVO next cycle. Buffer cleared, digitos=0, no pulses emitted, clave_ingresada keeps its last value.
- INACTIVO: sensor high -> ESPERA_D1 with buffer cleared. Keys are ignored while in INACTIVO.
- ESPERA_D1:
  - Digit -> stored as high nibble, digitos=1, go to ESPERA_D2.
  - ENTER -> error_entrada pulse, stay.
  - CLEAR -> stay.
- ESPERA_D2:
  - Digit -> stored as low nibble, digitos=2, go to ESPERA_ENTER.
  - ENTER -> error_entrada pulse, clear buffer, go to ESPERA_D1.
  - CLEAR -> clear buffer, go to ESPERA_D1.
- ESPERA_ENTER:
  - ENTER -> clave_ingresada <= {d1,d2}, clave_lista=1, go to ENTREGA.
  - Digit -> error_entrada pulse, clear buffer, go to ESPERA_D1. The offending digit is not kept.
  - CLEAR -> clear buffer, go to ESPERA_D1.
- ENTREGA:
  - Lasts exactly one cycle; clave_lista is deasserted when leaving.
  - Buffer cleared, digitos=0, go to ESPERA_D1 so the controller can receive further attempts.
  - Keys arriving in this cycle are ignored.
- Non-digit, non-ENTER, non-CLEAR codes (A, B, D, F with the defaults) are ignored in every state. They do not restart the timeout.
- Timeout:
  - Counter runs only in ESPERA_D2 and ESPERA_ENTER.
  - Reset to 0 on every accepted key (digit, ENTER, CLEAR) and on entering ESPERA_D1.
  - When the counter reaches TIMEOUT_CICLOS-1 with no key that cycle: tiempo_agotado pulse, clear buffer, go to ESPERA_D1.
  - A key arriving in the same cycle as expiry wins: it is processed normally, counter restarts, no tiempo_agotado.
  - Counter width is $clog2(TIMEOUT_CICLOS); it saturates and never wraps.
- Pulse exclusivity: clave_lista, error_entrada and tiempo_agotado are mutually exclusive in any cycle.
- Input assumption: tecla_valida held high for multiple cycles is treated as repeated keys. The scanner guarantees single-cycle strobes.
- Reset asserted mid-entry discards all state. No pulse appears in the cycle after reset.

Test Plan:
- Sensor high; keys 4, 7, ENTER on cycles 10, 12, 14 -> clave_lista=1 for exactly cycle 15, clave_ingresada=8'h47 held afterwards, digitos sequence 0,1,2,0.
- Sensor high; key 3 then ENTER -> error_entrada pulse the cycle after ENTER, digitos=0, no clave_lista. Then 1, 2, ENTER -> clave_ingresada=8'h12.
- TIMEOUT_CICLOS=8; key 5, then idle -> tiempo_agotado pulse exactly 8 cycles after the digit cycle, digitos=0. Repeat with a key in the expiry cycle -> no tiempo_agotado.
- Keys 9, 9, then sensor drops before ENTER -> INACTIVO, no pulses, clave_ingresada unchanged from the previous value (8'h00 after reset). Keys while the sensor is low are ignored.
- Keys 1, 2, 3 -> error_entrada on the third key. Then CLEAR, 8, 0, ENTER -> clave_ingresada=8'h80. Key code 4'hA injected mid-sequence has no effect.
- Reset asserted while in ESPERA_ENTER holding 8'h56 -> all outputs zero next cycle. A following ENTER produces no clave_lista.
